// File: rtl/game_state_sequencer.sv
// Game state register and next-state arbiter. Commits the proposal owned by the
// current state, with pause, forced jumps, dwell timeout and illegal-target trapping.
module game_state_sequencer #(
   parameter int NUM_STATES    = 8,
   parameter int STATE_W       = 3,
   parameter int INIT_STATE    = 0,
   parameter int TIMEOUT_STATE = 7,
   parameter int CNT_W         = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_STATES*STATE_W-1:0] next_state_bus,
   input  logic [NUM_STATES-1:0]         next_valid,
   input  logic                          pause,
   input  logic                          force_valid,
   input  logic [STATE_W-1:0]            force_state,
   input  logic [CNT_W-1:0]              timeout_limit,
   output logic [STATE_W-1:0]            current_state,
   output logic [STATE_W-1:0]            next_state,
   output logic [STATE_W-1:0]            prev_state,
   output logic                          state_entry,
   output logic [CNT_W-1:0]              dwell_cnt,
   output logic                          timeout_pulse,
   output logic                          illegal_err
);

   localparam logic [STATE_W-1:0] INIT_S    = STATE_W'(INIT_STATE);
   localparam logic [STATE_W-1:0] TIMEOUT_S = STATE_W'(TIMEOUT_STATE);

   logic [STATE_W-1:0] current_state_q, current_state_d;
   logic [STATE_W-1:0] prev_state_q, prev_state_d;
   logic               state_entry_q, state_entry_d;
   logic [CNT_W-1:0]   dwell_cnt_q, dwell_cnt_d;
   logic               timeout_pulse_q, timeout_pulse_d;
   logic               illegal_err_q, illegal_err_d;

   logic [STATE_W-1:0] prop [NUM_STATES];
   logic [STATE_W-1:0] own_prop;
   logic [STATE_W-1:0] target;
   logic [CNT_W-1:0]   limit_m1;
   logic               own_valid;
   logic               timeout_hit;
   logic               cur_bad;
   logic               req;
   logic               via_timeout;
   logic               tgt_bad;
   logic               transition;

   generate
      for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_prop
         assign prop[gi] = next_state_bus[gi*STATE_W +: STATE_W];
      end
   endgenerate

   always_comb begin
      own_valid = 1'b0;
      own_prop  = current_state_q;
      for (int k = 0; k < NUM_STATES; k++) begin
         if (current_state_q == STATE_W'(k)) begin
            own_valid = next_valid[k];
            own_prop  = prop[k];
         end
      end

      limit_m1    = timeout_limit - CNT_W'(1);
      timeout_hit = (timeout_limit != '0) && (dwell_cnt_q >= limit_m1);
      cur_bad     = int'(current_state_q) >= NUM_STATES;

      req         = 1'b0;
      target      = current_state_q;
      via_timeout = 1'b0;
      if (force_valid) begin
         req    = 1'b1;
         target = force_state;
      end else if (pause) begin
         req    = 1'b0;
      end else if (own_valid) begin
         req    = 1'b1;
         target = own_prop;
      end else if (timeout_hit) begin
         req         = 1'b1;
         target      = TIMEOUT_S;
         via_timeout = 1'b1;
      end

      // An out-of-range target degrades the cycle to a plain hold.
      tgt_bad    = req && (int'(target) >= NUM_STATES);
      transition = req && !tgt_bad;
      current_state_d = transition ? target : current_state_q;

      // A corrupted current state recovers straight to the initial state.
      if (cur_bad) begin
         transition      = 1'b1;
         via_timeout     = 1'b0;
         current_state_d = INIT_S;
      end

      prev_state_d    = transition ? current_state_q : prev_state_q;
      state_entry_d   = transition;
      timeout_pulse_d = transition && via_timeout;
      illegal_err_d   = illegal_err_q | tgt_bad | cur_bad;

      if (transition)
         dwell_cnt_d = '0;
      else if ((pause && !force_valid) || (dwell_cnt_q == {CNT_W{1'b1}}))
         dwell_cnt_d = dwell_cnt_q;
      else
         dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         current_state_q <= INIT_S;
         prev_state_q    <= INIT_S;
         state_entry_q   <= 1'b1;
         dwell_cnt_q     <= '0;
         timeout_pulse_q <= 1'b0;
         illegal_err_q   <= 1'b0;
      end else begin
         current_state_q <= current_state_d;
         prev_state_q    <= prev_state_d;
         state_entry_q   <= state_entry_d;
         dwell_cnt_q     <= dwell_cnt_d;
         timeout_pulse_q <= timeout_pulse_d;
         illegal_err_q   <= illegal_err_d;
      end
   end

   assign current_state = current_state_q;
   assign next_state    = current_state_d;
   assign prev_state    = prev_state_q;
   assign state_entry   = state_entry_q;
   assign dwell_cnt     = dwell_cnt_q;
   assign timeout_pulse = timeout_pulse_q;
   assign illegal_err   = illegal_err_q;

endmodule

// File: doc/game_state_sequencer.md
Name: game_state_sequencer

Overview:
- Parametrised top-level game state register and next-state arbiter; successor to the fixed 8-state, 3-bit selector.
- Each game phase module drives a proposed next state plus a valid request. The sequencer commits the proposal owned by the current state.
- Adds pause, forced jump, per-state dwell counting, a dwell timeout, entry pulses, previous-state history and illegal-state detection.
- Sits between the phase modules (initial, generate, rotate, collision, clear, move, tobottom, lose) and all consumers of the current state.

Parameters:
- NUM_STATES, 8, number of legal states; encodings 0..NUM_STATES-1.
- STATE_W, 3, state encoding width; must satisfy 2^STATE_W >= NUM_STATES.
- INIT_STATE, 0, state loaded on reset.
- TIMEOUT_STATE, 7, state entered when a dwell timeout fires (the lose state by default).
- CNT_W, 16, width of the dwell counter and of the timeout limit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- next_state_bus  in  NUM_STATES*STATE_W  proposal of state k in bits [k*STATE_W +: STATE_W].
- next_valid  in  NUM_STATES  bit k = state k requests a transition this cycle.
- pause  in  1  freeze: no transitions, dwell counter held.
- force_valid  in  1  jump request; overrides pause.
- force_state  in  STATE_W  target state of a forced jump.
- timeout_limit  in  CNT_W  dwell limit in cycles; 0 disables the timeout.
- current_state  out  STATE_W  registered current state.
- next_state  out  STATE_W  combinational state for the next cycle.
- prev_state  out  STATE_W  registered state held before the last commit.
- state_entry  out  1  registered; high for the first cycle of each newly entered state.
- dwell_cnt  out  CNT_W  cycles spent in current_state since entry, saturating.
- timeout_pulse  out  1  registered one-cycle pulse; the state was entered via timeout.
- illegal_err  out  1  sticky; set on any illegal target.

Behaviour:
- Reset values: current_state=INIT_STATE, prev_state=INIT_STATE, state_entry=1, dwell_cnt=0, timeout_pulse=0, illegal_err=0. Reset mid-operation aborts all state immediately, at the same edge.
- Commit: at each clk edge, current_state <= next_state.
- next_state arbitration, evaluated in priority order:
  1. force_valid=1 -> force_state.
  2. pause=1 -> current_state (hold).
  3. next_valid[current_state]=1 -> proposal of current_state.
  4. timeout_limit!=0 and dwell_cnt >= timeout_limit-1 -> TIMEOUT_STATE.
  5. Otherwise -> current_state.
- Only the entry for current_state is consulted; valid bits and proposals of other states are ignored.
- A "transition" is any commit through rule 1, 3 or 4, including a self-transition (target == current_state).
- Illegal target: any selected target >= NUM_STATES, from force, proposal or a misconfigured TIMEOUT_STATE.
  - No transition occurs; the cycle is treated as a hold.
  - illegal_err <= 1 and stays set until rst.
  - next_state shows current_state.
- If current_state is ever >= NUM_STATES: next_state = INIT_STATE, and illegal_err is set.
- On a transition:
  - prev_state <= old current_state.
  - state_entry <= 1.
  - dwell_cnt <= 0.
  - timeout_pulse <= 1 only if rule 4 selected.
- Otherwise:
  - state_entry <= 0 and timeout_pulse <= 0.
  - dwell_cnt <= dwell_cnt+1, saturating at 2^CNT_W-1, except held when pause=1 and force_valid=0.
- Timeout latency: with no requests and limit L, entry at cycle 0 -> TIMEOUT_STATE is current at cycle L, and timeout_pulse is high in that same cycle.
- Simultaneous request and timeout: the request (rule 3) wins and no timeout_pulse is produced.
- Timeout while already in TIMEOUT_STATE re-enters it: state_entry=1, timeout_pulse=1, dwell_cnt=0.
- Changing timeout_limit mid-state takes effect immediately against the current dwell_cnt.

Test Plan:
- Reset, then default chain: assert rst 2 cycles. Expect current_state=0, state_entry=1, illegal_err=0. Release rst; next_valid[0]=1 with proposal 1 -> current_state=1 next cycle, prev_state=0, state_entry=1 for 1 cycle.
- Non-owner ignored: in state 1, next_valid=8'b1111_1101 with all proposals=5. Expect no transition, dwell_cnt counting 0,1,2...
- Pause/force: in state 2, pause=1 with next_valid[2]=1 for 5 cycles -> state 2 and dwell_cnt held. Then force_valid=1, force_state=6 while still paused -> current_state=6 next cycle, dwell_cnt=0.
- Timeout: timeout_limit=4 in state 3, no requests. Expect current_state=7 exactly 4 cycles after entry, timeout_pulse=1 for 1 cycle. Repeat with next_valid[3]=1 (proposal 4) asserted at dwell_cnt=3 -> state 4, timeout_pulse=0.
- Illegal target: NUM_STATES=6, proposal 7 with valid -> state held, illegal_err=1. Assert rst -> illegal_err=0.
- Saturation and mid-op reset: CNT_W=4, timeout off, hold 20 cycles -> dwell_cnt stuck at 15. Assert rst during a request cycle -> current_state=INIT_STATE, prev_state=INIT_STATE, state_entry=1.
